riscv_instr_loader: RTL and testbench
=====================================

# riscv_instr_loader

Downstream consumer of the leaf extract stage's RISC-V instruction path. Takes the registered `instr_packet`/`instr_wr_en` word stream and the level `ap_start` from the extract stage, parses a header word, and writes the following payload words into the leaf's instruction memory at auto-incrementing addresses. Holds the core in reset while loading, and releases it only when a completed image exists and `ap_start` is high.

## Interface
- `IMEM_ADDR_BITS`, default 12: instruction memory word-address width.
- `LEN_BITS`, default 16: payload length field width; must be ≤ 16.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `instr_packet`  in  32  instruction/header word; valid when `instr_wr_en`=1.
- `instr_wr_en`  in  1  single-cycle word strobe.
- `ap_start`  in  1  level run request.
- `imem_we`  out  1  instruction memory write enable.
- `imem_addr`  out  IMEM_ADDR_BITS  write word address.
- `imem_wdata`  out  32  write data.
- `core_reset`  out  1  active-high reset to the RISC-V core.
- `load_done`  out  1  sticky; a complete image is present.
- `proto_err`  out  1  sticky; a word arrived in RUN.
- `checksum_err`  out  1  sticky checksum mismatch; see Configuration.

## Operation
- States:
  - IDLE: awaiting a header or start.
  - LOAD: receiving payload.
  - CHK: awaiting the checksum word; only when the macro is defined.
  - RUN: core released.
- Header word, accepted in IDLE on `instr_wr_en`:
  - `[31:16]` = start word address, truncated to IMEM_ADDR_BITS.
  - `[LEN_BITS-1:0]` = payload length N.
  - Accepting a header clears `load_done` and `checksum_err`.
- N>0: go to LOAD. Addr counter = start; remaining = N.
- N=0: stay in IDLE. Set `load_done` next cycle. No writes.
- LOAD, on each `instr_wr_en`:
  - Write the word at the addr counter.
  - Increment the addr counter modulo 2^IMEM_ADDR_BITS; wrap from all-ones to 0 is silent.
  - Decrement remaining.
  - On the word taking remaining 1→0: go to CHK if enabled, else IDLE with `load_done`=1.
- `ap_start` is ignored in LOAD/CHK. The load always completes first.
- IDLE → RUN when `ap_start`=1 and `load_done`=1.
- RUN → IDLE when `ap_start`=0.
- Any `instr_wr_en` in RUN:
  - The word is discarded and no write occurs.
  - `proto_err` is set.
- A new header in IDLE after a completed load starts a fresh image.
- `core_reset`=0 only in RUN; 1 in every other state.
- Reset values:
  - State = IDLE.
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `core_reset`=1.
  - `load_done`=0, `proto_err`=0, `checksum_err`=0.
- Reset mid-LOAD abandons the image. `load_done` stays 0 until a new complete load.

## Timing
- `imem_we`/`imem_addr`/`imem_wdata` are registered: asserted in cycle T+1 for a strobe in cycle T. `imem_we` is high exactly one cycle per payload word.
- Back-to-back strobes on consecutive cycles are supported at full rate. There is no backpressure.
- `load_done` rises in cycle T+1 after the final payload word, or after the checksum word when the macro is defined.
- `core_reset` deasserts in cycle T+1 after the first cycle T where IDLE, `ap_start`=1 and `load_done`=1 all hold.
- `core_reset` reasserts in cycle T+1 after `ap_start` is sampled 0.
- Same-cycle `ap_start`=1 and header strobe in IDLE: the header wins. The block enters LOAD and `load_done` clears.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - One extra word follows the payload, handled in state CHK.
  - That word is compared against the XOR of all N payload words. It is never written to memory.
  - Mismatch sets `checksum_err` and leaves `load_done`=0. Either way the state returns to IDLE.
  - For N=0 no checksum word is expected.
- `LOADER_CHECKSUM_EN` undefined:
  - No CHK state and no XOR register.
  - `checksum_err` is tied 0.

## Structure
- The shared leaf package holds:
  - the state enum `{IDLE, LOAD, CHK, RUN}`;
  - header field positions (`HDR_ADDR_MSB`=31, `HDR_ADDR_LSB`=16);
  - the instruction word width constant, 32.
- No sub-module. Single flat block.

## Test plan
- Header `0x0010_0003`, then words A,B,C on consecutive cycles → writes (0x010,A), (0x011,B), (0x012,C) on cycles T+1..T+3. `load_done`=1 after C; `core_reset` stays 1.
- After a complete load, raise `ap_start` → `core_reset`=0 one cycle later. Drop `ap_start` → `core_reset`=1 one cycle later, state back in IDLE.
- IMEM_ADDR_BITS=12, header `0x0FFF_0002`, words X,Y → writes at 0xFFF then 0x000.
- Raise `ap_start` mid-LOAD with 2 of 4 words sent → `core_reset` stays 1. Send the remaining 2 words → `core_reset`=0 two cycles after the last word.
- In RUN, pulse `instr_wr_en` → no `imem_we`, `proto_err`=1, `core_reset` still 0.
- With `LOADER_CHECKSUM_EN`:
  - Header N=2, words 0x1, 0x2, checksum 0x3 → `load_done`=1, `checksum_err`=0.
  - Same load with checksum 0x4 → `checksum_err`=1, `load_done`=0.

Source files
------------

// File: rtl/riscv_instr_loader_pkg.sv
// Shared leaf definitions for the RISC-V instruction loader: FSM states,
// header field positions and the instruction word width.
package riscv_instr_loader_pkg;

   localparam int INSTR_W      = 32;
   localparam int HDR_ADDR_MSB = 31;
   localparam int HDR_ADDR_LSB = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CHK  = 2'd2,
      RUN  = 2'd3
   } loader_state_t;

endpackage

// File: rtl/riscv_instr_loader.sv
// Parses a header word, then writes N payload words to imem (registered, 1 cycle), full rate, no backpressure.
// Holds core_reset high until an image is complete and ap_start is high; LOADER_CHECKSUM_EN adds an XOR checksum word.
module riscv_instr_loader
   import riscv_instr_loader_pkg::*;
#(
   parameter int IMEM_ADDR_BITS = 12,
   parameter int LEN_BITS       = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [INSTR_W-1:0]        instr_packet,
   input  logic                      instr_wr_en,
   input  logic                      ap_start,
   output logic                      imem_we,
   output logic [IMEM_ADDR_BITS-1:0] imem_addr,
   output logic [INSTR_W-1:0]        imem_wdata,
   output logic                      core_reset,
   output logic                      load_done,
   output logic                      proto_err,
   output logic                      checksum_err
);

   loader_state_t             state;
   logic [IMEM_ADDR_BITS-1:0] addr_cnt;
   logic [LEN_BITS-1:0]       remaining;
   logic [LEN_BITS-1:0]       hdr_len;
   logic [IMEM_ADDR_BITS-1:0] hdr_addr;

   assign hdr_len  = instr_packet[LEN_BITS-1:0];
   assign hdr_addr = IMEM_ADDR_BITS'(instr_packet[HDR_ADDR_MSB:HDR_ADDR_LSB]);

   // The core only runs while the FSM sits in RUN, so this follows the state register directly.
   assign core_reset = (state != RUN);

`ifdef LOADER_CHECKSUM_EN
   logic [INSTR_W-1:0] xor_acc;
`else
   assign checksum_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         addr_cnt   <= '0;
         remaining  <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         load_done  <= 1'b0;
         proto_err  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         xor_acc      <= '0;
         checksum_err <= 1'b0;
`endif
      end else begin
         imem_we <= 1'b0;
         case (state)
            IDLE: begin
               // A header outranks a same-cycle run request: the old image is replaced.
               if (instr_wr_en) begin
                  addr_cnt  <= hdr_addr;
                  remaining <= hdr_len;
                  load_done <= (hdr_len == '0);
`ifdef LOADER_CHECKSUM_EN
                  xor_acc      <= '0;
                  checksum_err <= 1'b0;
`endif
                  if (hdr_len != '0) begin
                     state <= LOAD;
                  end
               end else if (ap_start && load_done) begin
                  state <= RUN;
               end
            end

            LOAD: begin
               if (instr_wr_en) begin
                  imem_we    <= 1'b1;
                  imem_addr  <= addr_cnt;
                  imem_wdata <= instr_packet;
                  addr_cnt   <= addr_cnt + IMEM_ADDR_BITS'(1);
                  remaining  <= remaining - LEN_BITS'(1);
`ifdef LOADER_CHECKSUM_EN
                  xor_acc <= xor_acc ^ instr_packet;
                  if (remaining == LEN_BITS'(1)) begin
                     state <= CHK;
                  end
`else
                  if (remaining == LEN_BITS'(1)) begin
                     state     <= IDLE;
                     load_done <= 1'b1;
                  end
`endif
               end
            end

`ifdef LOADER_CHECKSUM_EN
            CHK: begin
               if (instr_wr_en) begin
                  if (instr_packet == xor_acc) begin
                     load_done <= 1'b1;
                  end else begin
                     checksum_err <= 1'b1;
                  end
                  state <= IDLE;
               end
            end
`endif

            RUN: begin
               if (instr_wr_en) begin
                  proto_err <= 1'b1;
               end
               if (!ap_start) begin
                  state <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_instr_loader.sv
// Directed bench for riscv_instr_loader: load, run, wrap, mid-load start, protocol error and reset cases.
// Define LOADER_CHECKSUM_EN for both bench and RTL to exercise the checksum path.
module tb_riscv_instr_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr_packet;
   logic        instr_wr_en;
   logic        ap_start;
   logic        imem_we;
   logic [11:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        core_reset;
   logic        load_done;
   logic        proto_err;
   logic        checksum_err;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] pl[8];
   int          pl_n;
   int          start_at;
   logic [31:0] pl_xor;

   riscv_instr_loader #(.IMEM_ADDR_BITS(12), .LEN_BITS(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .instr_packet (instr_packet),
      .instr_wr_en  (instr_wr_en),
      .ap_start     (ap_start),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .core_reset   (core_reset),
      .load_done    (load_done),
      .proto_err    (proto_err),
      .checksum_err (checksum_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_header(input logic [31:0] h);
      instr_wr_en  = 1'b1;
      instr_packet = h;
      tick();
      instr_wr_en  = 1'b0;
      n_cmp++;
      if (imem_we !== 1'b0) begin
         n_err++; $display("FAIL hdr_no_write h=%h imem_we=%b want 0", h, imem_we);
      end
   endtask

   // Streams pl[0..pl_n-1] back to back right after the header and checks each registered write.
   task automatic send_payload(input logic [11:0] start);
      logic [11:0] ea;
      pl_xor = '0;
      for (int i = 0; i < pl_n; i++) begin
         if (i == start_at) ap_start = 1'b1;
         instr_wr_en  = 1'b1;
         instr_packet = pl[i];
         pl_xor       = pl_xor ^ pl[i];
         tick();
         ea = start + 12'(i);
         n_cmp++;
         if (imem_we !== 1'b1 || imem_addr !== ea || imem_wdata !== pl[i]) begin
            n_err++;
            $display("FAIL write[%0d] we=%b addr=%h data=%h want we=1 addr=%h data=%h",
                     i, imem_we, imem_addr, imem_wdata, ea, pl[i]);
         end
         n_cmp++;
         if (core_reset !== 1'b1) begin
            n_err++; $display("FAIL load_core_reset[%0d] got %b want 1", i, core_reset);
         end
      end
      instr_wr_en = 1'b0;
   endtask

   task automatic finish_image();
`ifdef LOADER_CHECKSUM_EN
      instr_wr_en  = 1'b1;
      instr_packet = pl_xor;
      tick();
      instr_wr_en  = 1'b0;
      n_cmp++;
      if (imem_we !== 1'b0) begin
         n_err++; $display("FAIL csum_no_write imem_we=%b want 0", imem_we);
      end
`endif
   endtask

   task automatic test_reset();
      reset = 1'b1; instr_wr_en = 1'b0; instr_packet = '0; ap_start = 1'b0;
      repeat (3) tick();
      n_cmp++; if (imem_we !== 1'b0)      begin n_err++; $display("FAIL rst_we got %b want 0", imem_we); end
      n_cmp++; if (imem_addr !== 12'h0)   begin n_err++; $display("FAIL rst_addr got %h want 000", imem_addr); end
      n_cmp++; if (imem_wdata !== 32'h0)  begin n_err++; $display("FAIL rst_wdata got %h want 0", imem_wdata); end
      n_cmp++; if (core_reset !== 1'b1)   begin n_err++; $display("FAIL rst_core_reset got %b want 1", core_reset); end
      n_cmp++; if (load_done !== 1'b0)    begin n_err++; $display("FAIL rst_load_done got %b want 0", load_done); end
      n_cmp++; if (proto_err !== 1'b0)    begin n_err++; $display("FAIL rst_proto_err got %b want 0", proto_err); end
      n_cmp++; if (checksum_err !== 1'b0) begin n_err++; $display("FAIL rst_checksum_err got %b want 0", checksum_err); end
      reset = 1'b0;
      ap_start = 1'b1;
      tick();
      n_cmp++; if (core_reset !== 1'b1)   begin n_err++; $display("FAIL start_no_image got %b want 1", core_reset); end
      ap_start = 1'b0;
      tick();
   endtask

   task automatic test_basic_load();
      start_at = -1;
      pl_n = 3; pl[0] = 32'hDEAD_BEEF; pl[1] = 32'h1234_5678; pl[2] = 32'hCAFE_F00D;
      send_header(32'h0010_0003);
      n_cmp++; if (load_done !== 1'b0) begin n_err++; $display("FAIL basic_done_early got %b want 0", load_done); end
      send_payload(12'h010);
      finish_image();
      n_cmp++; if (load_done !== 1'b1)  begin n_err++; $display("FAIL basic_load_done got %b want 1", load_done); end
      n_cmp++; if (core_reset !== 1'b1) begin n_err++; $display("FAIL basic_core_reset got %b want 1", core_reset); end
      tick();
      n_cmp++; if (imem_we !== 1'b0)    begin n_err++; $display("FAIL basic_we_idle got %b want 0", imem_we); end
   endtask

   task automatic test_run();
      ap_start = 1'b1;
      tick();
      n_cmp++; if (core_reset !== 1'b0) begin n_err++; $display("FAIL run_release got %b want 0", core_reset); end
      tick();
      n_cmp++; if (core_reset !== 1'b0) begin n_err++; $display("FAIL run_hold got %b want 0", core_reset); end
      ap_start = 1'b0;
      tick();
      n_cmp++; if (core_reset !== 1'b1) begin n_err++; $display("FAIL run_stop got %b want 1", core_reset); end
      n_cmp++; if (load_done !== 1'b1)  begin n_err++; $display("FAIL run_done_kept got %b want 1", load_done); end
   endtask

   task automatic test_wrap();
      start_at = -1;
      pl_n = 2; pl[0] = 32'hAAAA_0001; pl[1] = 32'h5555_0002;
      send_header(32'h0FFF_0002);
      n_cmp++; if (load_done !== 1'b0) begin n_err++; $display("FAIL wrap_hdr_clears got %b want 0", load_done); end
      send_payload(12'hFFF);
      finish_image();
      n_cmp++; if (load_done !== 1'b1) begin n_err++; $display("FAIL wrap_done got %b want 1", load_done); end
   endtask

   task automatic test_start_mid_load();
      start_at = 2;
      pl_n = 4; pl[0] = 32'h0000_0011; pl[1] = 32'h0000_0022; pl[2] = 32'h0000_0033; pl[3] = 32'h0000_0044;
      send_header(32'h0200_0004);
      send_payload(12'h200);
      finish_image();
      n_cmp++; if (core_reset !== 1'b1) begin n_err++; $display("FAIL mid_t1_core_reset got %b want 1", core_reset); end
      n_cmp++; if (load_done !== 1'b1)  begin n_err++; $display("FAIL mid_done got %b want 1", load_done); end
      tick();
      n_cmp++; if (core_reset !== 1'b0) begin n_err++; $display("FAIL mid_t2_release got %b want 0", core_reset); end
      start_at = -1;
   endtask

   task automatic test_run_proto();
      instr_wr_en = 1'b1; instr_packet = 32'h5A5A_5A5A;
      tick();
      instr_wr_en = 1'b0;
      n_cmp++; if (imem_we !== 1'b0)    begin n_err++; $display("FAIL proto_no_write got %b want 0", imem_we); end
      n_cmp++; if (proto_err !== 1'b1)  begin n_err++; $display("FAIL proto_err got %b want 1", proto_err); end
      n_cmp++; if (core_reset !== 1'b0) begin n_err++; $display("FAIL proto_core_run got %b want 0", core_reset); end
      tick();
      n_cmp++; if (proto_err !== 1'b1)  begin n_err++; $display("FAIL proto_sticky got %b want 1", proto_err); end
      ap_start = 1'b0;
      tick();
      n_cmp++; if (core_reset !== 1'b1) begin n_err++; $display("FAIL proto_stop got %b want 1", core_reset); end
   endtask

   task automatic test_header_wins();
      ap_start = 1'b1;
      pl_n = 1; pl[0] = 32'h0BAD_F00D;
      send_header(32'h0300_0001);
      n_cmp++; if (load_done !== 1'b0)  begin n_err++; $display("FAIL hw_done_cleared got %b want 0", load_done); end
      n_cmp++; if (core_reset !== 1'b1) begin n_err++; $display("FAIL hw_core_reset got %b want 1", core_reset); end
      send_payload(12'h300);
      finish_image();
      n_cmp++; if (core_reset !== 1'b1) begin n_err++; $display("FAIL hw_t1_core_reset got %b want 1", core_reset); end
      tick();
      n_cmp++; if (core_reset !== 1'b0) begin n_err++; $display("FAIL hw_release got %b want 0", core_reset); end
      ap_start = 1'b0;
      tick();
   endtask

   task automatic test_zero_len();
      send_header(32'h0400_0000);
      n_cmp++; if (load_done !== 1'b1) begin n_err++; $display("FAIL zero_done got %b want 1", load_done); end
      tick();
      n_cmp++; if (imem_we !== 1'b0)   begin n_err++; $display("FAIL zero_no_write got %b want 0", imem_we); end
      ap_start = 1'b1;
      tick();
      n_cmp++; if (core_reset !== 1'b0) begin n_err++; $display("FAIL zero_release got %b want 0", core_reset); end
      ap_start = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_load();
      send_header(32'h0600_0003);
      instr_wr_en = 1'b1; instr_packet = 32'h7777_7777;
      tick();
      instr_wr_en = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      n_cmp++; if (load_done !== 1'b0)  begin n_err++; $display("FAIL rml_done got %b want 0", load_done); end
      n_cmp++; if (proto_err !== 1'b0)  begin n_err++; $display("FAIL rml_proto got %b want 0", proto_err); end
      n_cmp++; if (imem_we !== 1'b0)    begin n_err++; $display("FAIL rml_we got %b want 0", imem_we); end
      ap_start = 1'b1;
      repeat (2) tick();
      n_cmp++; if (core_reset !== 1'b1) begin n_err++; $display("FAIL rml_no_release got %b want 1", core_reset); end
      ap_start = 1'b0;
      tick();
   endtask

`ifdef LOADER_CHECKSUM_EN
   task automatic test_checksum();
      pl_n = 2; pl[0] = 32'h1; pl[1] = 32'h2;
      send_header(32'h0500_0002);
      send_payload(12'h500);
      instr_wr_en = 1'b1; instr_packet = 32'h3;
      tick();
      instr_wr_en = 1'b0;
      n_cmp++; if (load_done !== 1'b1)    begin n_err++; $display("FAIL csum_ok_done got %b want 1", load_done); end
      n_cmp++; if (checksum_err !== 1'b0) begin n_err++; $display("FAIL csum_ok_err got %b want 0", checksum_err); end
      send_header(32'h0500_0002);
      send_payload(12'h500);
      instr_wr_en = 1'b1; instr_packet = 32'h4;
      tick();
      instr_wr_en = 1'b0;
      n_cmp++; if (imem_we !== 1'b0)      begin n_err++; $display("FAIL csum_bad_we got %b want 0", imem_we); end
      n_cmp++; if (load_done !== 1'b0)    begin n_err++; $display("FAIL csum_bad_done got %b want 0", load_done); end
      n_cmp++; if (checksum_err !== 1'b1) begin n_err++; $display("FAIL csum_bad_err got %b want 1", checksum_err); end
      ap_start = 1'b1;
      repeat (2) tick();
      n_cmp++; if (core_reset !== 1'b1)   begin n_err++; $display("FAIL csum_bad_hold got %b want 1", core_reset); end
      ap_start = 1'b0;
      tick();
   endtask
`endif

   initial begin
      start_at = -1;
      pl_n     = 0;
      pl_xor   = '0;
      test_reset();
      test_basic_load();
      test_run();
      test_wrap();
      test_start_mid_load();
      test_run_proto();
      test_header_wins();
      test_zero_len();
      test_reset_mid_load();
`ifdef LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
